// File: rtl/exec_stage_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_stage_mc_if
//  Description : Bundle interface for exec_stage_mc. It carries the operand
//                handshake from decode/register-read, the result handshake to
//                writeback, and the flush strobe.
//                master : the surrounding pipeline (drives operands, out_ready)
//                slave  : the execute stage (drives in_ready and results)
//  Revision    : 1.0  initial release
// ============================================================================
interface exec_stage_mc_if #(
   parameter int DW = 16,
   parameter int AW = 8,
   parameter int RW = 4
);
   // Operand side
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] do1;
   logic [DW-1:0] do2;
   logic [DW-1:0] imm;
   logic [RW-1:0] dest;
   logic [2:0]    alucnt;
   logic          sel;
   logic          wes;
   logic [1:0]    branchs;
   logic [AW-1:0] disp;
   logic [AW-1:0] nxtadrs;
   // Result side
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] wdata_e;
   logic [RW-1:0] dest_e;
   logic          we_e;
   logic [AW-1:0] PCd;
   logic          bj;

   modport master (
      output flush, in_valid, do1, do2, imm, dest, alucnt, sel, wes,
             branchs, disp, nxtadrs, out_ready,
      input  in_ready, out_valid, wdata_e, dest_e, we_e, PCd, bj
   );

   modport slave (
      input  flush, in_valid, do1, do2, imm, dest, alucnt, sel, wes,
             branchs, disp, nxtadrs, out_ready,
      output in_ready, out_valid, wdata_e, dest_e, we_e, PCd, bj
   );
endinterface
`default_nettype wire

// File: rtl/exec_stage_mc.sv
`default_nettype none
// ============================================================================
//  Module      : exec_stage_mc
//  Description : Execute stage with valid/ready handshakes on both sides.
//                ALU (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA), immediate bypass,
//                branch compare and branch-target add. Shifts by n>0 run
//                iteratively at one bit per cycle (latency 1+n); every other
//                op completes in one cycle. The result sits in an output
//                register until the consumer accepts it.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - synchronous reset, active-high
//                bus  - exec_stage_mc_if.slave: flush, operand handshake
//                       (in_valid/in_ready, do1, do2, imm, dest, alucnt, sel,
//                       wes, branchs, disp, nxtadrs) and result handshake
//                       (out_valid/out_ready, wdata_e, dest_e, we_e, PCd, bj)
//  Revision    : 1.0  initial release
// ============================================================================
module exec_stage_mc #(
   parameter int DW = 16,
   parameter int AW = 8,
   parameter int RW = 4
) (
   input  wire logic       clk,
   input  wire logic       rst,
   exec_stage_mc_if.slave  bus
);
   localparam int SW = $clog2(DW);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Working state for an iterative shift
   logic [DW-1:0] r_work;
   logic [SW-1:0] r_cnt;
   logic [1:0]    r_sop;
   logic [RW-1:0] r_p_dest;
   logic          r_p_wes;
   logic [AW-1:0] r_p_pcd;
   logic          r_p_taken;

   // Output registers
   logic          r_out_valid;
   logic [DW-1:0] r_wdata;
   logic [RW-1:0] r_dest_e;
   logic          r_we;
   logic [AW-1:0] r_pcd;
   logic          r_taken;

   logic          w_in_ready;
   logic          w_accept;
   logic [SW-1:0] w_amt;
   logic          w_is_shift;
   logic          w_shift_start;
   logic          w_load_single;
   logic          w_shift_done;
   logic [DW-1:0] w_alu;
   logic [DW-1:0] w_result;
   logic          w_taken;
   logic [AW-1:0] w_pcd;
   logic [DW-1:0] w_shift1;

   assign w_in_ready    = !rst && !bus.flush && (r_state == S_IDLE) &&
                          (!r_out_valid || bus.out_ready);
   assign w_accept      = bus.in_valid && w_in_ready;
   assign w_amt         = bus.do2[SW-1:0];
   // alucnt 5..7 are the shifts; the immediate bypass never shifts
   assign w_is_shift    = !bus.sel && bus.alucnt[2] && (bus.alucnt[1:0] != 2'b00);
   assign w_shift_start = w_accept && w_is_shift && (w_amt != '0);
   assign w_load_single = w_accept && !w_shift_start;
   assign w_shift_done  = (r_state == S_SHIFT) && (r_cnt == SW'(1));
   assign w_pcd         = bus.nxtadrs + bus.disp;
   assign w_result      = bus.sel ? bus.imm : w_alu;

   // Single-cycle ALU; a shift reaching here has amount 0, so it passes do1
   always_comb begin
      w_alu = bus.do1;
      case (bus.alucnt)
         3'd0:    w_alu = bus.do1 + bus.do2;
         3'd1:    w_alu = bus.do1 - bus.do2;
         3'd2:    w_alu = bus.do1 & bus.do2;
         3'd3:    w_alu = bus.do1 | bus.do2;
         3'd4:    w_alu = bus.do1 ^ bus.do2;
         default: w_alu = bus.do1;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (bus.branchs)
         2'd1:    w_taken = (bus.do1 == bus.do2);
         2'd2:    w_taken = (bus.do1 != bus.do2);
         2'd3:    w_taken = ($signed(bus.do1) < $signed(bus.do2));
         default: w_taken = 1'b0;
      endcase
   end

   // One-bit step of the working register; r_sop holds alucnt[1:0]
   always_comb begin
      w_shift1 = {r_work[DW-1], r_work[DW-1:1]};
      case (r_sop)
         2'b01:   w_shift1 = {r_work[DW-2:0], 1'b0};
         2'b10:   w_shift1 = {1'b0, r_work[DW-1:1]};
         default: w_shift1 = {r_work[DW-1], r_work[DW-1:1]};
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      if (bus.flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_shift_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == SW'(1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work      <= '0;
         r_cnt       <= '0;
         r_sop       <= '0;
         r_p_dest    <= '0;
         r_p_wes     <= 1'b0;
         r_p_pcd     <= '0;
         r_p_taken   <= 1'b0;
         r_out_valid <= 1'b0;
         r_wdata     <= '0;
         r_dest_e    <= '0;
         r_we        <= 1'b0;
         r_pcd       <= '0;
         r_taken     <= 1'b0;
      end else if (bus.flush) begin
         // Any in-flight shift is dropped; data registers are left as-is
         r_out_valid <= 1'b0;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            r_work    <= bus.do1;
            r_cnt     <= w_shift_start ? w_amt : '0;
            r_sop     <= bus.alucnt[1:0];
            r_p_dest  <= bus.dest;
            r_p_wes   <= bus.wes;
            r_p_pcd   <= w_pcd;
            r_p_taken <= w_taken;
         end else if (r_state == S_SHIFT) begin
            r_work <= w_shift1;
            r_cnt  <= r_cnt - SW'(1);
         end

         if (w_load_single) begin
            r_out_valid <= 1'b1;
            r_wdata     <= w_result;
            r_dest_e    <= bus.dest;
            r_we        <= bus.wes;
            r_pcd       <= w_pcd;
            r_taken     <= w_taken;
         end else if (w_shift_done) begin
            // A shift only starts once the previous result has drained,
            // so the output register is free when the last step lands
            r_out_valid <= 1'b1;
            r_wdata     <= w_shift1;
            r_dest_e    <= r_p_dest;
            r_we        <= r_p_wes;
            r_pcd       <= r_p_pcd;
            r_taken     <= r_p_taken;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.wdata_e   = r_wdata;
   assign bus.dest_e    = r_dest_e;
   assign bus.we_e      = r_we && r_out_valid;
   assign bus.PCd       = r_pcd;
   assign bus.bj        = r_taken && r_out_valid;

endmodule
`default_nettype wire
